// File: rtl/retire_rob.sv
// rtl/retire_rob.sv - reorder buffer with in-order, multi-slot registered retirement
// Dispatch allocates in order, writeback completes by tag, oldest done entries retire to the regfile.
module retire_rob #(
  parameter  int DEPTH     = 8,
  parameter  int RET_WIDTH = 2,
  parameter  int XLEN      = 32,
  parameter  int REG_AW    = 5,
  localparam int TAG_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(RET_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic                        alloc_dst_vld,
  input  logic [REG_AW-1:0]           alloc_dst,
  output logic [TAG_W-1:0]            alloc_tag,
  input  logic                        wb_valid,
  input  logic [TAG_W-1:0]            wb_tag,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        flush,
  output logic [RET_WIDTH-1:0]        wren_rb0,
  output logic [RET_WIDTH*REG_AW-1:0] wraddr_rb0,
  output logic [RET_WIDTH*XLEN-1:0]   wrdata_rb0,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [TAG_W:0]              occupancy
);

  localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]    head, tail;
  logic [DEPTH-1:0]  valid_q, done_q, dst_vld_q;
  logic [REG_AW-1:0] dst_q  [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];

  logic [TAG_W-1:0]     tail_idx;
  logic                 alloc_fire, wb_fire;
  logic [RET_WIDTH-1:0] elig;
  logic [TAG_W-1:0]     sel_idx [RET_WIDTH];
  logic [CNT_W-1:0]     n_ret;

  assign occupancy   = tail - head;
  assign alloc_ready = (occupancy != FULL);
  assign tail_idx    = tail[TAG_W-1:0];
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign wb_fire     = wb_valid & valid_q[wb_tag] & ~done_q[wb_tag];

  // A slot is eligible only while every older slot is also valid and done.
  always_comb begin
    logic chain;
    chain = 1'b1;
    elig  = '0;
    n_ret = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      sel_idx[i] = head[TAG_W-1:0] + TAG_W'(i);
      chain      = chain & valid_q[sel_idx[i]] & done_q[sel_idx[i]];
      elig[i]    = chain;
      if (chain) n_ret = n_ret + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      wren_rb0   <= '0;
      wraddr_rb0 <= '0;
      wrdata_rb0 <= '0;
      retire_cnt <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      wren_rb0   <= '0;
      wraddr_rb0 <= '0;
      wrdata_rb0 <= '0;
      retire_cnt <= '0;
    end else begin
      for (int i = 0; i < RET_WIDTH; i++) begin
        // Writes to x0 are dropped but the entry still counts as retired.
        wren_rb0[i] <= elig[i] & dst_vld_q[sel_idx[i]] & (|dst_q[sel_idx[i]]);
        wraddr_rb0[i*REG_AW +: REG_AW] <= elig[i] ? dst_q[sel_idx[i]] : '0;
        wrdata_rb0[i*XLEN +: XLEN]     <= elig[i] ? data_q[sel_idx[i]] : '0;
        if (elig[i]) begin
          valid_q[sel_idx[i]] <= 1'b0;
          done_q[sel_idx[i]]  <= 1'b0;
        end
      end
      retire_cnt <= n_ret;
      head       <= head + (TAG_W + 1)'(n_ret);
      if (wb_fire) done_q[wb_tag] <= 1'b1;
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + (TAG_W + 1)'(1);
      end
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dst_vld_q[tail_idx] <= alloc_dst_vld;
      dst_q[tail_idx]     <= alloc_dst;
    end
    if (wb_fire) data_q[wb_tag] <= wb_data;
  end

  wb_legal: assert property (@(posedge clk) disable iff (!reset)
    (wb_valid && !flush) |-> (valid_q[wb_tag] && !done_q[wb_tag]));

endmodule

// File: tb/tb_retire_rob.sv
// tb/tb_retire_rob.sv - scoreboard bench for retire_rob
module tb_retire_rob;
  localparam int DEPTH = 8;
  localparam int RW    = 2;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           alloc_valid = 1'b0, alloc_ready, alloc_dst_vld = 1'b0;
  logic [AW-1:0]  alloc_dst = '0;
  logic [2:0]     alloc_tag;
  logic           wb_valid = 1'b0;
  logic [2:0]     wb_tag = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic           flush = 1'b0;
  logic [RW-1:0]  wren_rb0;
  logic [RW*AW-1:0]   wraddr_rb0;
  logic [RW*XLEN-1:0] wrdata_rb0;
  logic [1:0]     retire_cnt;
  logic [3:0]     occupancy;

  retire_rob #(.DEPTH(DEPTH), .RET_WIDTH(RW), .XLEN(XLEN), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_dst_vld(alloc_dst_vld), .alloc_dst(alloc_dst), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .flush(flush),
    .wren_rb0(wren_rb0), .wraddr_rb0(wraddr_rb0), .wrdata_rb0(wrdata_rb0),
    .retire_cnt(retire_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] dst;
    logic [31:0]   data;
  } ret_t;

  ret_t        exp_q[$];
  logic [2:0]  pend_q[$];
  logic [31:0] plan_data [8];
  logic [31:0] cur_pd = '0;
  logic [2:0]  mtail = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_retire();
    ret_t e;
    for (int i = 0; i < RW; i++) begin
      if (i < int'(retire_cnt)) begin
        if (exp_q.size() == 0) begin
          check("retire_unexpected", 64'(retire_cnt), 64'(i));
        end else begin
          e = exp_q.pop_front();
          check("wren", 64'(wren_rb0[i]), 64'(e.wr));
          check("wraddr", 64'(wraddr_rb0[i*AW +: AW]), 64'(e.dst));
          check("wrdata", 64'(wrdata_rb0[i*XLEN +: XLEN]), 64'(e.data));
        end
      end else begin
        check("idle_slot", 64'({wren_rb0[i], wraddr_rb0[i*AW +: AW], wrdata_rb0[i*XLEN +: XLEN]}), 64'(0));
      end
    end
  endtask

  // Expected retirements are queued in program order as allocations are accepted.
  task automatic tick();
    ret_t e;
    if (alloc_valid && alloc_ready && !flush) begin
      check("alloc_tag", 64'(alloc_tag), 64'(mtail));
      e.wr   = alloc_dst_vld && (alloc_dst != '0);
      e.dst  = alloc_dst;
      e.data = cur_pd;
      exp_q.push_back(e);
      plan_data[mtail] = cur_pd;
      mtail++;
    end
    if (flush) begin
      exp_q.delete();
      mtail = '0;
    end
    @(posedge clk);
    #1;
    check_retire();
  endtask

  task automatic step(input logic av, input logic dv, input logic [AW-1:0] d, input logic [31:0] pd,
                      input logic wv, input logic [2:0] wt);
    alloc_valid   = av;
    alloc_dst_vld = dv;
    alloc_dst     = d;
    cur_pd        = pd;
    wb_valid      = wv;
    wb_tag        = wt;
    wb_data       = wv ? plan_data[wt] : '0;
    flush         = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
    reset       = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ctl", 64'({wren_rb0, retire_cnt, wraddr_rb0}), 64'(0));
    check("rst_data", 64'(wrdata_rb0), 64'(0));
    check("rst_occ", 64'({alloc_ready, occupancy}), 64'({1'b1, 4'd0}));
    exp_q.delete();
    pend_q.delete();
    mtail = '0;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic       wv;
    logic [2:0] wt, base;

    do_reset();
    // In-order pair then single retirement
    step(1, 1, 5'd1, 32'd11, 0, 0);
    step(1, 1, 5'd2, 32'd22, 0, 0);
    step(1, 1, 5'd3, 32'd33, 0, 0);
    check("t1_occ", 64'(occupancy), 64'(3));
    step(0, 0, 0, 0, 1, 3'd1);
    check("t1_wren_a", 64'(wren_rb0), 64'(0));
    step(0, 0, 0, 0, 1, 3'd0);
    check("t1_wren_b", 64'(wren_rb0), 64'(0));
    step(0, 0, 0, 0, 1, 3'd2);
    check("t1_wren_pair", 64'(wren_rb0), 64'(2'b11));
    check("t1_cnt_pair", 64'(retire_cnt), 64'(2));
    step(0, 0, 0, 0, 0, 0);
    check("t1_wren_last", 64'(wren_rb0), 64'(2'b01));
    step(0, 0, 0, 0, 0, 0);
    check("t1_occ_end", 64'(occupancy), 64'(0));

    // Out-of-order completion
    do_reset();
    step(1, 1, 5'd5, 32'h55, 0, 0);
    step(1, 1, 5'd6, 32'h66, 0, 0);
    step(0, 0, 0, 0, 1, 3'd1);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 0, 0);
      check("t2_hold", 64'(wren_rb0), 64'(0));
    end
    step(0, 0, 0, 0, 1, 3'd0);
    check("t2_wb0_lat", 64'(wren_rb0), 64'(0));
    step(0, 0, 0, 0, 0, 0);
    check("t2_wren_pair", 64'(wren_rb0), 64'(2'b11));
    check("t2_wraddr", 64'(wraddr_rb0), 64'({5'd6, 5'd5}));

    // Full ROB back-pressure
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(1, 1, 5'(k + 1), 32'(100 + k), 0, 0);
    check("t3_full_ready", 64'(alloc_ready), 64'(0));
    check("t3_full_occ", 64'(occupancy), 64'(8));
    step(1, 1, 5'd9, 32'd999, 0, 0);
    check("t3_reject_occ", 64'(occupancy), 64'(8));
    step(0, 0, 0, 0, 1, 3'd0);
    check("t3_ready_wb", 64'(alloc_ready), 64'(0));
    step(0, 0, 0, 0, 0, 0);
    check("t3_ready_ret", 64'(alloc_ready), 64'(1));
    check("t3_cnt", 64'(retire_cnt), 64'(1));
    check("t3_occ", 64'(occupancy), 64'(7));

    // x0 and no-destination entries retire without writes
    do_reset();
    step(1, 1, 5'd0, 32'hA0, 0, 0);
    step(1, 0, 5'd7, 32'hB0, 0, 0);
    step(0, 0, 0, 0, 1, 3'd1);
    step(0, 0, 0, 0, 1, 3'd0);
    check("t4_cnt_wait", 64'(retire_cnt), 64'(0));
    step(0, 0, 0, 0, 0, 0);
    check("t4_cnt", 64'(retire_cnt), 64'(2));
    check("t4_wren", 64'(wren_rb0), 64'(0));

    // Streaming with pointer wrap, then flush with live entries
    do_reset();
    for (int k = 0; k < 20; k++) begin
      wv = 1'b0;
      wt = '0;
      if (pend_q.size() > 0) begin
        wv = 1'b1;
        wt = pend_q.pop_front();
      end
      pend_q.push_back(mtail);
      step(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, wv, wt);
    end
    while (pend_q.size() > 0) begin
      wt = pend_q.pop_front();
      step(0, 0, 0, 0, 1, wt);
    end
    for (int k = 0; k < 10 && occupancy != 0; k++) step(0, 0, 0, 0, 0, 0);
    check("t5_drain", 64'(occupancy), 64'(0));
    base = mtail;
    step(1, 1, 5'd10, 32'hC0, 0, 0);
    step(1, 1, 5'd11, 32'hC1, 0, 0);
    step(1, 1, 5'd12, 32'hC2, 1, base + 3'd1);
    step(1, 1, 5'd13, 32'hC3, 1, base + 3'd2);
    step(0, 0, 0, 0, 0, 0);
    check("t5_live", 64'(occupancy), 64'(4));
    alloc_valid = 1'b1; alloc_dst_vld = 1'b1; alloc_dst = 5'd3; cur_pd = 32'hDEAD;
    wb_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    check("t5_flush_occ", 64'(occupancy), 64'(0));
    check("t5_flush_tag", 64'(alloc_tag), 64'(0));
    check("t5_flush_cnt", 64'(retire_cnt), 64'(0));
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd4, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 1, 3'd0);
    step(0, 0, 0, 0, 0, 0);
    check("t5_post_flush", 64'(wren_rb0), 64'(2'b01));

    // Asynchronous reset with live entries
    do_reset();
    step(1, 1, 5'd1, 32'd11, 0, 0);
    step(1, 1, 5'd2, 32'd22, 0, 0);
    step(0, 0, 0, 0, 1, 3'd0);
    step(0, 0, 0, 0, 1, 3'd1);
    check("t6_pre", 64'(wren_rb0), 64'(2'b01));
    #2;
    reset = 1'b0;
    #1;
    check("t6_ctl", 64'({wren_rb0, retire_cnt, wraddr_rb0}), 64'(0));
    check("t6_data", 64'(wrdata_rb0), 64'(0));
    check("t6_occ", 64'({alloc_ready, occupancy}), 64'({1'b1, 4'd0}));
    exp_q.delete();
    mtail = '0;
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
